mc_control_unit: RTL and testbench

Multi-cycle control FSM for the 32-bit MIPS-subset CPU. It decodes the latched instruction opcode and sequences every instruction through IF/ID/EXE/MEM/WB states. It drives the register file write enable (`RegWre`) and write-register/write-data selects, plus the PC, IR, ALU and data-memory controls. It sits directly upstream of the register file and the datapath muxes.

---
 rtl/mc_control_unit.sv | 156 +++++++++++++++
 tb/tb_mc_control_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB
// and decodes the latched opcode into datapath selects and strobes.
module mc_control_unit (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] opcode,
   input  logic       zero,
   output logic [2:0] state,
   output logic       PCWre,
   output logic       IRWre,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrDataSrc,
   output logic       DBDataSrc,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       mRD,
   output logic       mWR
);

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   typedef enum logic [2:0] {
      S_IF      = 3'b000,
      S_ID      = 3'b001,
      S_EXE_AL  = 3'b010,
      S_WB_AL   = 3'b011,
      S_EXE_BR  = 3'b100,
      S_EXE_MEM = 3'b101,
      S_MEM     = 3'b110,
      S_WB_LD   = 3'b111
   } state_t;

   state_t cur, nxt;

   logic is_rtype, is_itype, is_alu, is_br, is_mem;

   // Opcode class decode
   assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
   assign is_itype = (opcode == OP_ADDIU) || (opcode == OP_ORI) || (opcode == OP_SLTI);
   assign is_alu   = is_rtype || is_itype;
   assign is_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
   assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cur <= S_IF;
      else      cur <= nxt;
   end

   assign state = cur;

   // Next state and per-state strobes
   always_comb begin
      nxt    = cur;
      PCWre  = 1'b0;
      IRWre  = 1'b0;
      RegWre = 1'b0;
      PCSrc  = 2'b00;
      mRD    = 1'b0;
      mWR    = 1'b0;
      case (cur)
         S_IF: begin
            IRWre = 1'b1;
            nxt   = S_ID;
         end
         S_ID: begin
            if (is_alu)                 nxt = S_EXE_AL;
            else if (is_br)             nxt = S_EXE_BR;
            else if (is_mem)            nxt = S_EXE_MEM;
            else if (opcode == OP_HALT) nxt = S_ID;
            else begin
               // jumps and undefined opcodes retire here
               nxt   = S_IF;
               PCWre = 1'b1;
               if (opcode == OP_JAL) RegWre = 1'b1;
               if ((opcode == OP_J) || (opcode == OP_JAL)) PCSrc = 2'b11;
               else if (opcode == OP_JR)                   PCSrc = 2'b10;
            end
         end
         S_EXE_AL: nxt = S_WB_AL;
         S_WB_AL: begin
            RegWre = 1'b1;
            PCWre  = 1'b1;
            nxt    = S_IF;
         end
         S_EXE_BR: begin
            PCWre = 1'b1;
            nxt   = S_IF;
            if (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero))
               PCSrc = 2'b01;
         end
         S_EXE_MEM: nxt = S_MEM;
         S_MEM: begin
            if (opcode == OP_LW) begin
               mRD = 1'b1;
               nxt = S_WB_LD;
            end else begin
               mWR   = 1'b1;
               PCWre = 1'b1;
               nxt   = S_IF;
            end
         end
         S_WB_LD: begin
            RegWre = 1'b1;
            PCWre  = 1'b1;
            nxt    = S_IF;
         end
         default: nxt = S_IF;
      endcase
   end

   // Opcode-only datapath selects, valid in every state
   always_comb begin
      RegDst    = 2'b00;
      WrDataSrc = 1'b0;
      DBDataSrc = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b1;
      ALUOp     = ALU_ADD;
      if (is_rtype)                       RegDst = 2'b10;
      else if (is_itype || opcode == OP_LW) RegDst = 2'b01;
      if (is_itype || is_mem) ALUSrcB = 1'b1;
      if (opcode == OP_ORI)   ExtSel = 1'b0;
      if (opcode == OP_LW)    DBDataSrc = 1'b1;
      if (opcode == OP_JAL)   WrDataSrc = 1'b1;
      case (opcode)
         OP_SUB, OP_BEQ, OP_BNE: ALUOp = ALU_SUB;
         OP_AND:                 ALUOp = ALU_AND;
         OP_ORI:                 ALUOp = ALU_OR;
         OP_SLTI:                ALUOp = ALU_SLT;
         default:                ALUOp = ALU_ADD;
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed-vector bench for mc_control_unit: an instruction-level model predicts
// each cycle's state and controls, checked on every falling edge.
module tb_mc_control_unit;

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b010000;
   localparam logic [5:0] ADDIU = 6'b000010, ORI = 6'b010010, SLTI = 6'b100111;
   localparam logic [5:0] SW = 6'b110000, LW = 6'b110001;
   localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101;
   localparam logic [5:0] J = 6'b111000, JAL = 6'b111010, JR = 6'b111001;
   localparam logic [5:0] HALT = 6'b111111, UNDEF = 6'b000011;

   logic       CLK = 1'b0;
   logic       RST;
   logic [5:0] opcode;
   logic       zero;
   logic [2:0] state;
   logic       PCWre, IRWre, RegWre;
   logic [1:0] RegDst;
   logic       WrDataSrc, DBDataSrc, ALUSrcB, ExtSel;
   logic [2:0] ALUOp;
   logic [1:0] PCSrc;
   logic       mRD, mWR;

   int total = 0;
   int bad   = 0;

   mc_control_unit dut (
      .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .state(state),
      .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
      .WrDataSrc(WrDataSrc), .DBDataSrc(DBDataSrc), .ALUSrcB(ALUSrcB),
      .ExtSel(ExtSel), .ALUOp(ALUOp), .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: how many cycles, and which phase is which
   function automatic int instr_len(input logic [5:0] op);
      case (op)
         ADD, SUB, AND_, ADDIU, ORI, SLTI, SW: return 4;
         LW:                                  return 5;
         BEQ, BNE:                            return 3;
         HALT:                                return 22;
         default:                             return 2;
      endcase
   endfunction

   function automatic logic [2:0] state_at(input logic [5:0] op, input int k);
      if (k == 0) return 3'd0;
      if (k == 1 || op == HALT) return 3'd1;
      case (op)
         ADD, SUB, AND_, ADDIU, ORI, SLTI: return (k == 2) ? 3'd2 : 3'd3;
         BEQ, BNE:                         return 3'd4;
         default:                          return (k == 2) ? 3'd5 : ((k == 3) ? 3'd6 : 3'd7);
      endcase
   endfunction

   logic       en = 1'b0;
   logic [2:0] e_state, e_aluop;
   logic       e_pc, e_ir, e_rw, e_wrsrc, e_dbsrc, e_alusrcb, e_ext, e_mrd, e_mwr;
   logic [1:0] e_regdst, e_pcsrc;
   logic       c_regdst, c_aluop;

   task automatic set_expect(input logic [5:0] op, input logic z, input int k, input int n);
      bit rtype, itype, last;
      rtype = (op == ADD) || (op == SUB) || (op == AND_);
      itype = (op == ADDIU) || (op == ORI) || (op == SLTI);
      last  = (k == n - 1) && (op != HALT);
      e_state   = state_at(op, k);
      e_ir      = (k == 0);
      e_pc      = last;
      e_rw      = last && (rtype || itype || op == LW || op == JAL);
      e_mrd     = (op == LW) && (k == 3);
      e_mwr     = (op == SW) && (k == 3);
      e_pcsrc   = 2'b00;
      if (last && (op == J || op == JAL)) e_pcsrc = 2'b11;
      if (last && op == JR)               e_pcsrc = 2'b10;
      if (last && ((op == BEQ && z) || (op == BNE && !z))) e_pcsrc = 2'b01;
      e_alusrcb = itype || op == LW || op == SW;
      e_ext     = (op != ORI);
      e_dbsrc   = (op == LW);
      e_wrsrc   = (op == JAL);
      c_regdst  = rtype || itype || op == LW || op == JAL;
      e_regdst  = rtype ? 2'b10 : ((op == JAL) ? 2'b00 : 2'b01);
      c_aluop   = rtype || itype || op == LW || op == SW || op == BEQ || op == BNE;
      case (op)
         SUB, BEQ, BNE: e_aluop = 3'b001;
         AND_:          e_aluop = 3'b010;
         ORI:           e_aluop = 3'b011;
         SLTI:          e_aluop = 3'b100;
         default:       e_aluop = 3'b000;
      endcase
   endtask

   // Compare process: checks every meaningful cycle mid-way, clear of the rising edge
   always @(negedge CLK) begin
      if (en) begin
         chk("state", 32'(state), 32'(e_state));
         chk("PCWre", 32'(PCWre), 32'(e_pc));
         chk("IRWre", 32'(IRWre), 32'(e_ir));
         chk("RegWre", 32'(RegWre), 32'(e_rw));
         chk("mRD", 32'(mRD), 32'(e_mrd));
         chk("mWR", 32'(mWR), 32'(e_mwr));
         chk("PCSrc", 32'(PCSrc), 32'(e_pcsrc));
         chk("ALUSrcB", 32'(ALUSrcB), 32'(e_alusrcb));
         chk("ExtSel", 32'(ExtSel), 32'(e_ext));
         chk("DBDataSrc", 32'(DBDataSrc), 32'(e_dbsrc));
         chk("WrDataSrc", 32'(WrDataSrc), 32'(e_wrsrc));
         if (c_regdst) chk("RegDst", 32'(RegDst), 32'(e_regdst));
         if (c_aluop)  chk("ALUOp", 32'(ALUOp), 32'(e_aluop));
      end
   end

   // Runs one instruction starting in IF, just after a rising edge
   task automatic run_instr(input logic [5:0] op, input logic z);
      int n;
      n = instr_len(op);
      opcode = op;
      zero   = z;
      for (int k = 0; k < n; k++) begin
         set_expect(op, z, k, n);
         en = 1'b1;
         #1;
         if (op == ADD && k == 3) begin
            chk("lit_add_wb_state", 32'(state), 32'd3);
            chk("lit_add_wb_regdst", 32'(RegDst), 32'd2);
         end
         if (op == LW && k == 4) chk("lit_lw_last_state", 32'(state), 32'd7);
         if (op == BEQ && z && k == 2) chk("lit_beq_taken_pcsrc", 32'(PCSrc), 32'd1);
         if (op == BNE && z && k == 2) chk("lit_bne_nottaken_pcsrc", 32'(PCSrc), 32'd0);
         if (op == JAL && k == 1) begin
            chk("lit_jal_regwre", 32'(RegWre), 32'd1);
            chk("lit_jal_regdst", 32'(RegDst), 32'd0);
            chk("lit_jal_pcsrc", 32'(PCSrc), 32'd3);
         end
         @(posedge CLK);
         #1;
      end
      en = 1'b0;
   endtask

   initial begin
      RST    = 1'b0;
      opcode = ADD;
      zero   = 1'b0;
      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_irwre", 32'(IRWre), 32'd1);
      chk("rst_pcwre", 32'(PCWre), 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;

      run_instr(ADD, 1'b0);
      run_instr(SUB, 1'b1);
      run_instr(AND_, 1'b0);
      run_instr(ADDIU, 1'b0);
      run_instr(ORI, 1'b1);
      run_instr(SLTI, 1'b0);
      run_instr(LW, 1'b0);
      run_instr(SW, 1'b1);
      run_instr(BEQ, 1'b1);
      run_instr(BEQ, 1'b0);
      run_instr(BNE, 1'b1);
      run_instr(BNE, 1'b0);
      run_instr(J, 1'b0);
      run_instr(JAL, 1'b1);
      run_instr(JR, 1'b0);
      run_instr(UNDEF, 1'b0);
      run_instr(ADD, 1'b0);

      // Reset while add sits in WB_AL: must take effect with no clock edge
      opcode = ADD;
      repeat (3) @(posedge CLK);
      #1;
      chk("mid_pre_state", 32'(state), 32'd3);
      #2;
      RST = 1'b0;
      #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_regwre", 32'(RegWre), 32'd0);
      chk("mid_rst_irwre", 32'(IRWre), 32'd1);
      chk("mid_rst_pcwre", 32'(PCWre), 32'd0);
      chk("mid_rst_pcsrc", 32'(PCSrc), 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("post_rst_first_edge", 32'(state), 32'd1);
      RST = 1'b0;
      #1;
      @(posedge CLK);
      #1;
      RST = 1'b1;

      run_instr(LW, 1'b1);
      run_instr(HALT, 1'b0);
      chk("halt_held_state", 32'(state), 32'd1);
      chk("halt_pcwre", 32'(PCWre), 32'd0);
      RST = 1'b0;
      #1;
      chk("halt_rst_state", 32'(state), 32'd0);
      chk("halt_rst_irwre", 32'(IRWre), 32'd1);
      #10;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
